// File: rtl/clock_div_meter.sv
// Measures a divided clock against the clock that feeds the divider.
//
// The meter samples div_clk with clk and counts how many clk cycles pass
// between two rising edges of div_clk, and how many of those cycles div_clk
// was high. It compares each measured period with the programmed divide value.
// It asserts locked after LOCK_COUNT matching periods in a row. If no edge
// arrives for TIMEOUT cycles, it sets a sticky timeout flag.
//
// Ports:
//   clk          timebase; the same clock that drives the divider
//   reset        synchronous, active-high
//   div_clk      divided clock under test (asynchronous, synchronized here)
//   enable       measurement enable; dropping it returns to idle and clears flags
//   expected_n   programmed divide value; 0 and 1 mean bypass (no comparison)
//   period       last rising-to-rising period in clk cycles
//   high_time    clk cycles div_clk was sampled high within that period
//   period_valid one-cycle pulse when period/high_time update
//   locked       LOCK_COUNT consecutive periods equal to expected_n
//   mismatch     one-cycle pulse with period_valid when the period is wrong
//   timeout      sticky; no rising edge within TIMEOUT cycles
module clock_div_meter #(
  parameter int unsigned SIZE       = 3,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             enable,
  input  logic [SIZE-1:0]  expected_n,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LockCnt     = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q, tcnt_q;
  logic [3:0]       match_q;
  logic [SIZE-1:0]  exp_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             period_valid_q, locked_q, mismatch_q, timeout_q;

  logic             rise;
  logic             tmo_hit;
  logic             exp_changed;
  logic             bypass;
  logic             period_match;
  logic [CNT_W-1:0] cnt_inc, hcnt_inc;
  logic [3:0]       match_next;

  always_comb begin
    rise         = s2_q & ~s3_q;
    tmo_hit      = (tcnt_q == TimeoutLast);
    exp_changed  = (expected_n != exp_q);
    bypass       = ({1'b0, expected_n} < (SIZE + 1)'(2));
    period_match = (cnt_q == CNT_W'(expected_n));
    // Counters saturate at all-ones rather than wrapping.
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    hcnt_inc     = (s2_q && !(&hcnt_q)) ? hcnt_q + 1'b1 : hcnt_q;
    match_next   = (match_q >= LockCnt) ? LockCnt : match_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= '0;
      hcnt_q         <= '0;
      tcnt_q         <= '0;
      match_q        <= '0;
      exp_q          <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      mismatch_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      s1_q           <= div_clk;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      exp_q          <= expected_n;
      period_valid_q <= 1'b0;
      mismatch_q     <= 1'b0;

      if (!enable) begin
        // period/high_time keep their last values for readback.
        state_q   <= StIdle;
        cnt_q     <= '0;
        hcnt_q    <= '0;
        tcnt_q    <= '0;
        match_q   <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q   <= '0;
            hcnt_q  <= '0;
            tcnt_q  <= '0;
            state_q <= StArm;
          end
          StArm: begin
            if (rise) begin
              cnt_q   <= CNT_W'(1);
              hcnt_q  <= CNT_W'(1);
              tcnt_q  <= '0;
              state_q <= StMeas;
            end else if (tmo_hit) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
              tcnt_q    <= '0;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          StMeas: begin
            if (rise) begin
              // The rise cycle itself is the first cycle of the next period.
              period_q       <= cnt_q;
              high_time_q    <= hcnt_q;
              period_valid_q <= 1'b1;
              cnt_q          <= CNT_W'(1);
              hcnt_q         <= CNT_W'(1);
              tcnt_q         <= '0;
              if (bypass) begin
                match_q  <= '0;
                locked_q <= 1'b0;
              end else if (period_match) begin
                match_q  <= match_next;
                locked_q <= (match_next == LockCnt);
              end else begin
                mismatch_q <= 1'b1;
                match_q    <= '0;
                locked_q   <= 1'b0;
              end
            end else if (tmo_hit) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
              cnt_q     <= '0;
              hcnt_q    <= '0;
              tcnt_q    <= '0;
              state_q   <= StArm;
            end else begin
              cnt_q  <= cnt_inc;
              hcnt_q <= hcnt_inc;
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase

        // A new divide value invalidates any lock history; overrides the compare.
        if (exp_changed) begin
          match_q  <= '0;
          locked_q <= 1'b0;
        end
      end
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_div_meter.sv
// Self-checking bench for clock_div_meter. The driver generates a divider
// waveform cycle by cycle. It measures each rising-to-rising interval of that
// waveform directly and pushes the expected readback into a scoreboard. A
// monitor pops the scoreboard whenever the DUT pulses period_valid.
module tb_clock_div_meter;

  localparam int unsigned SIZE       = 3;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned TIMEOUT    = 1024;
  localparam int unsigned LOCK_COUNT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_clk;
  logic             enable;
  logic [SIZE-1:0]  expected_n;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  clock_div_meter #(
    .SIZE      (SIZE),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div_clk     (div_clk),
    .enable      (enable),
    .expected_n  (expected_n),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .mismatch    (mismatch),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    int lk;
    int mm;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: waveform history and lock streak.
  int since      = 0;
  int hi_cnt     = 0;
  int streak     = 0;
  bit have_rise  = 0;
  bit prev_v     = 0;
  bit chk_unlock = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // A period just completed; judge it against the current divide value.
  function automatic void push_period();
    exp_t x;
    int   e;
    e    = int'(expected_n);
    x.per = since;
    x.hi  = hi_cnt;
    if (e < 2) begin
      streak = 0;
      x.lk   = 0;
      x.mm   = 0;
    end else if (since == e) begin
      if (streak < int'(LOCK_COUNT)) streak++;
      x.lk = (streak == int'(LOCK_COUNT)) ? 1 : 0;
      x.mm = 0;
    end else begin
      streak = 0;
      x.lk   = 0;
      x.mm   = 1;
    end
    sb_q.push_back(x);
  endfunction

  task automatic drive_cycle(input bit v, input logic [SIZE-1:0] e);
    @(posedge clk);
    #1;
    if (chk_unlock) begin
      check_val("locked_drop_after_exp_change", locked, 0);
      chk_unlock = 0;
    end
    if (e != expected_n) begin
      expected_n = e;
      streak     = 0;
      if (enable) chk_unlock = 1;
    end
    if (v && !prev_v) begin
      if (have_rise) push_period();
      since     = 0;
      hi_cnt    = 0;
      have_rise = 1;
    end
    since++;
    hi_cnt += int'(v);
    prev_v  = v;
    div_clk = v;
  endtask

  task automatic idle(input int k);
    repeat (k) drive_cycle(1'b0, expected_n);
  endtask

  // n-cycle divider period, high for h cycles, for cnt periods, with divide value e.
  task automatic run_seg(input int n, input int h, input int e, input int cnt);
    for (int p = 0; p < cnt; p++)
      for (int c = 0; c < n; c++)
        drive_cycle(c < h, SIZE'(e));
  endtask

  task automatic drain();
    idle(8);
    check_val("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic restart_model();
    have_rise = 0;
    streak    = 0;
  endtask

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_period_valid: period=%0d high=%0d, none expected at %0t",
                 period, high_time, $time);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        checks++;
        if (period !== CNT_W'(x.per) || high_time !== CNT_W'(x.hi) ||
            locked !== x.lk[0] || mismatch !== x.mm[0] || timeout !== 1'b0) begin
          failures++;
          $display("FAIL readback: got per=%0d hi=%0d lk=%0b mm=%0b to=%0b expected per=%0d hi=%0d lk=%0d mm=%0d to=0 at %0t",
                   period, high_time, locked, mismatch, timeout, x.per, x.hi, x.lk, x.mm,
                   $time);
        end
      end
    end else if (reset === 1'b0) begin
      check_val("mismatch_without_valid", mismatch, 0);
    end
  end

  initial begin
    int n, h, e;
    reset      = 1'b1;
    div_clk    = 1'b0;
    enable     = 1'b0;
    expected_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_period", period, 0);
    check_val("rst_high_time", high_time, 0);
    check_val("rst_period_valid", period_valid, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_mismatch", mismatch, 0);
    check_val("rst_timeout", timeout, 0);
    reset = 1'b0;

    idle(2);
    enable = 1'b1;
    restart_model();
    idle(2);

    run_seg(4, 2, 4, 8);  // even N: locks on the 4th valid
    run_seg(6, 3, 6, 8);  // switch while locked
    run_seg(5, 2, 5, 6);  // odd N, short high
    run_seg(5, 3, 5, 6);  // odd N, long high
    run_seg(4, 2, 6, 6);  // wrong divide value: mismatch on every valid
    run_seg(3, 1, 1, 5);  // bypass value: no compare

    for (int s = 0; s < 12; s++) begin
      n = $urandom_range(3, 7);
      h = ($urandom_range(0, 1) == 1) ? (n + 1) / 2 : n / 2;
      e = ($urandom_range(0, 3) != 0) ? n : $urandom_range(0, 7);
      run_seg(n, h, e, $urandom_range(2, 7));
    end

    // Synchronous reset mid-measurement, enable left high.
    run_seg(4, 2, 4, 5);
    drain();
    reset = 1'b1;
    idle(1);
    check_val("midrst_period", period, 0);
    check_val("midrst_high_time", high_time, 0);
    check_val("midrst_period_valid", period_valid, 0);
    check_val("midrst_locked", locked, 0);
    check_val("midrst_mismatch", mismatch, 0);
    check_val("midrst_timeout", timeout, 0);
    reset = 1'b0;
    restart_model();
    run_seg(4, 2, 4, 6);
    drain();

    // Loss of clock: div_clk held low from the moment the meter arms.
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    restart_model();
    repeat (TIMEOUT) drive_cycle(1'b0, expected_n);
    check_val("timeout_before_limit", timeout, 0);
    drive_cycle(1'b0, expected_n);
    check_val("timeout_at_limit", timeout, 1);
    check_val("timeout_locked", locked, 0);
    idle(5);
    check_val("timeout_sticky", timeout, 1);
    enable = 1'b0;
    idle(1);
    check_val("timeout_cleared_by_enable", timeout, 0);
    check_val("period_retained_when_disabled", period, 4);
    enable = 1'b1;
    restart_model();
    idle(2);

    run_seg(3, 2, 3, 6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
